// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg_pkg
// Description : Shared pipeline definitions used by decode, the ID/EX
//               register and execute: field widths, writeback-select
//               encodings and the bundled control word.
// Revision    : 1.0  initial release
// ============================================================================
package id_ex_reg_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int ALU_CTRL_W   = 4;
    localparam int RESULT_SRC_W = 2;

    // Writeback source select carried down the pipe
    typedef enum logic [RESULT_SRC_W-1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10,
        RESULT_IMM = 2'b11
    } result_src_e;

    // Control word travelling with each instruction
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic                  valid;
        result_src_e           result_src;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } ctrl_t;

    // A bubble is an all-zero control word: no writes, not valid
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : id_ex_reg_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Synchronous active-high clear.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Clear on reset; otherwise count increments until it reaches all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : Decode-to-execute pipeline register with stall (hold),
//               flush (bubble insert) and a saturating bubble counter.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stallE,
    input  logic                    flushE,
    input  logic [XLEN-1:0]         pcD,
    input  logic [XLEN-1:0]         pcPlus4D,
    input  logic [XLEN-1:0]         rd1D,
    input  logic [XLEN-1:0]         rd2D,
    input  logic [XLEN-1:0]         immD,
    input  logic [REG_IDX_W-1:0]    rs1D,
    input  logic [REG_IDX_W-1:0]    rs2D,
    input  logic [REG_IDX_W-1:0]    rdD,
    input  logic                    regWriteD,
    input  logic                    memWriteD,
    input  logic                    jumpD,
    input  logic                    branchD,
    input  logic                    aluSrcD,
    input  logic                    validD,
    input  logic [RESULT_SRC_W-1:0] resultSrcD,
    input  logic [ALU_CTRL_W-1:0]   aluCtrlD,
    output logic [XLEN-1:0]         pcE,
    output logic [XLEN-1:0]         pcPlus4E,
    output logic [XLEN-1:0]         rd1E,
    output logic [XLEN-1:0]         rd2E,
    output logic [XLEN-1:0]         immE,
    output logic [REG_IDX_W-1:0]    rs1E,
    output logic [REG_IDX_W-1:0]    rs2E,
    output logic [REG_IDX_W-1:0]    rdE,
    output logic                    regWriteE,
    output logic                    memWriteE,
    output logic                    jumpE,
    output logic                    branchE,
    output logic                    aluSrcE,
    output logic                    validE,
    output logic [RESULT_SRC_W-1:0] resultSrcE,
    output logic [ALU_CTRL_W-1:0]   aluCtrlE,
    output logic [CNT_W-1:0]        bubbleCnt
);

    // Everything the E stage needs, kept as one packed word
    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        ctrl_t                ctrl;
    } id_ex_t;

    id_ex_t e_q;
    id_ex_t e_d;
    ctrl_t  ctrl_in;

    // Gather decode controls into the control word; immD is passed as raw bits
    always_comb begin
        ctrl_in            = CTRL_BUBBLE;
        ctrl_in.reg_write  = regWriteD;
        ctrl_in.mem_write  = memWriteD;
        ctrl_in.jump       = jumpD;
        ctrl_in.branch     = branchD;
        ctrl_in.alu_src    = aluSrcD;
        ctrl_in.valid      = validD;
        ctrl_in.result_src = result_src_e'(resultSrcD);
        ctrl_in.alu_ctrl   = aluCtrlD;
    end

    // Next-state: flush wins over stall; stall holds; otherwise load decode
    always_comb begin
        e_d = e_q;
        if (flushE) begin
            e_d = '0;
        end else if (!stallE) begin
            e_d.pc       = pcD;
            e_d.pc_plus4 = pcPlus4D;
            e_d.rd1      = rd1D;
            e_d.rd2      = rd2D;
            e_d.imm      = immD;
            e_d.rs1      = rs1D;
            e_d.rs2      = rs2D;
            e_d.rd       = rdD;
            e_d.ctrl     = ctrl_in;
        end
    end

    // Pipeline register; reset overrides flush, stall and data
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // Counts every flushed edge; stalls never touch it
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flushE),
        .count (bubbleCnt)
    );

    assign pcE        = e_q.pc;
    assign pcPlus4E   = e_q.pc_plus4;
    assign rd1E       = e_q.rd1;
    assign rd2E       = e_q.rd2;
    assign immE       = e_q.imm;
    assign rs1E       = e_q.rs1;
    assign rs2E       = e_q.rs2;
    assign rdE        = e_q.rd;
    assign regWriteE  = e_q.ctrl.reg_write;
    assign memWriteE  = e_q.ctrl.mem_write;
    assign jumpE      = e_q.ctrl.jump;
    assign branchE    = e_q.ctrl.branch;
    assign aluSrcE    = e_q.ctrl.alu_src;
    assign validE     = e_q.ctrl.valid;
    assign resultSrcE = e_q.ctrl.result_src;
    assign aluCtrlE   = e_q.ctrl.alu_ctrl;

endmodule : id_ex_reg
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg: directed scenarios plus
//               randomized stall/flush/reset traffic against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int VW    = 5*XLEN + 3*5 + 6 + 2 + 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, stallE, flushE;
    logic [XLEN-1:0] pcD, pcPlus4D, rd1D, rd2D, immD;
    logic [4:0] rs1D, rs2D, rdD;
    logic regWriteD, memWriteD, jumpD, branchD, aluSrcD, validD;
    logic [1:0] resultSrcD;
    logic [3:0] aluCtrlD;
    logic [XLEN-1:0] pcE, pcPlus4E, rd1E, rd2E, immE;
    logic [4:0] rs1E, rs2E, rdE;
    logic regWriteE, memWriteE, jumpE, branchE, aluSrcE, validE;
    logic [1:0] resultSrcE;
    logic [3:0] aluCtrlE;
    logic [CNT_W-1:0] bubbleCnt;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
        .pcD(pcD), .pcPlus4D(pcPlus4D), .rd1D(rd1D), .rd2D(rd2D), .immD(immD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .regWriteD(regWriteD), .memWriteD(memWriteD), .jumpD(jumpD),
        .branchD(branchD), .aluSrcD(aluSrcD), .validD(validD),
        .resultSrcD(resultSrcD), .aluCtrlD(aluCtrlD),
        .pcE(pcE), .pcPlus4E(pcPlus4E), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .jumpE(jumpE),
        .branchE(branchE), .aluSrcE(aluSrcE), .validE(validE),
        .resultSrcE(resultSrcE), .aluCtrlE(aluCtrlE),
        .bubbleCnt(bubbleCnt)
    );

    // Inputs and outputs flattened in the same field order
    logic [VW-1:0] d_vec, e_vec;
    assign d_vec = {pcD, pcPlus4D, rd1D, rd2D, immD, rs1D, rs2D, rdD,
                    regWriteD, memWriteD, jumpD, branchD, aluSrcD, validD,
                    resultSrcD, aluCtrlD};
    assign e_vec = {pcE, pcPlus4E, rd1E, rd2E, immE, rs1E, rs2E, rdE,
                    regWriteE, memWriteE, jumpE, branchE, aluSrcE, validE,
                    resultSrcE, aluCtrlE};

    // Reference model: what E must hold after each edge
    logic [VW-1:0] exp_vec = '0;
    int            exp_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_vec = '0;
            exp_cnt = 0;
        end else if (flushE) begin
            exp_vec = '0;
            exp_cnt = (exp_cnt >= CMAX) ? CMAX : exp_cnt + 1;
        end else if (!stallE) begin
            exp_vec = d_vec;
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;
    int   lit_sel = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Single compare process: model every cycle, plus literal pins on request
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_e", e_vec, exp_vec);
            chk("model_cnt", VW'(bubbleCnt), VW'(exp_cnt));
            case (lit_sel)
                1: begin
                    chk("reset_outputs", e_vec, '0);
                    chk("reset_cnt", VW'(bubbleCnt), '0);
                end
                2: begin
                    chk("norm_imm", VW'(immE), VW'(32'hFFFFF800));
                    chk("norm_rd", VW'(rdE), VW'(5));
                    chk("norm_regwrite", VW'(regWriteE), VW'(1));
                end
                3: chk("stall_pc", VW'(pcE), VW'(32'h100));
                4: chk("release_pc", VW'(pcE), VW'(32'h104));
                5: begin
                    chk("flush_memwrite", VW'(memWriteE), '0);
                    chk("flush_valid", VW'(validE), '0);
                    chk("flush_all_zero", e_vec, '0);
                    chk("flush_cnt", VW'(bubbleCnt), VW'(1));
                end
                6: chk("sat_cnt", VW'(bubbleCnt), VW'(4'hF));
                7: chk("stall_rd7", VW'(rdE), VW'(7));
                8: begin
                    chk("post_rst_rd", VW'(rdE), VW'(9));
                    chk("post_rst_pc", VW'(pcE), VW'(32'h200));
                    chk("post_rst_valid", VW'(validE), VW'(1));
                end
                default: ;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_sel = 0;
    endtask

    task automatic rand_d();
        pcD = $urandom; pcPlus4D = $urandom; rd1D = $urandom; rd2D = $urandom;
        immD = $urandom;
        rs1D = 5'($urandom); rs2D = 5'($urandom); rdD = 5'($urandom);
        regWriteD = 1'($urandom); memWriteD = 1'($urandom); jumpD = 1'($urandom);
        branchD = 1'($urandom); aluSrcD = 1'($urandom); validD = 1'($urandom);
        resultSrcD = 2'($urandom); aluCtrlD = 4'($urandom);
    endtask

    initial begin
        rand_d();
        rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
        cyc(); chk_en = 1'b1; lit_sel = 1;

        // Normal load
        rst = 1'b0; rand_d();
        immD = 32'hFFFFF800; rdD = 5'd5; regWriteD = 1'b1;
        cyc(); lit_sel = 2;

        // Stall holds, release loads
        rand_d(); pcD = 32'h100;
        cyc(); lit_sel = 3;
        stallE = 1'b1; rand_d(); pcD = 32'h104;
        for (int i = 0; i < 3; i++) begin cyc(); lit_sel = 3; end
        stallE = 1'b0;
        cyc(); lit_sel = 4;

        // Flush beats stall; repeated flush+stall counts each edge
        rst = 1'b1; cyc(); lit_sel = 1;
        rst = 1'b0; flushE = 1'b1; stallE = 1'b1; rand_d(); memWriteD = 1'b1; validD = 1'b1;
        cyc(); lit_sel = 5;
        for (int i = 0; i < 3; i++) begin rand_d(); cyc(); end

        // Saturation
        rst = 1'b1; flushE = 1'b0; stallE = 1'b0; cyc(); lit_sel = 1;
        rst = 1'b0; flushE = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            rand_d(); cyc();
            if (k >= 15) lit_sel = 6;
        end

        // Reset in the middle of a stall
        flushE = 1'b0; rand_d(); rdD = 5'd7;
        cyc(); lit_sel = 7;
        stallE = 1'b1; rand_d();
        cyc(); lit_sel = 7;
        rst = 1'b1; rand_d();
        cyc(); lit_sel = 1;
        rst = 1'b0; stallE = 1'b0; rand_d(); rdD = 5'd9; pcD = 32'h200; validD = 1'b1;
        cyc(); lit_sel = 8;

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            rand_d();
            rst    = ($urandom_range(0, 63) == 0);
            flushE = ($urandom_range(0, 7) == 0);
            stallE = ($urandom_range(0, 3) == 0);
            cyc();
        end

        rst = 1'b0; flushE = 1'b0; stallE = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_id_ex_reg
`default_nettype wire
